// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, serializer state encoding and the parity helper.
package uart_mmio_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_LEVEL  = 2'd2;

    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_BUSY_BIT  = 3;
    localparam int STAT_OVF_BIT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: valid/ready byte input, start/data/stop framing.
// Defining UART_MMIO_TX_PARITY_EN inserts an even-parity bit before STOP.
module uart_tx_serializer
    import uart_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       busy,
    output logic       uart_tx
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_r;
    tx_state_e   state_next_s;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        uart_tx_r;
    logic        tx_next_s;
    logic        baud_done_s;

    assign baud_done_s = (baud_cnt_r == BAUD_LAST);
    assign byte_ready  = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign uart_tx     = uart_tx_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Baud/bit counters and byte capture; counters sit at zero while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
        end else if (state_r == ST_IDLE) begin
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            if (byte_valid) begin
                shift_r <= byte_data;
            end
        end else begin
            baud_cnt_r <= baud_done_s ? 16'd0 : baud_cnt_r + 16'd1;
            if ((state_r == ST_DATA) && baud_done_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = byte_valid ? ST_START : ST_IDLE;
            ST_START: state_next_s = baud_done_s ? ST_DATA : ST_START;
`ifdef UART_MMIO_TX_PARITY_EN
            ST_DATA:   state_next_s = (baud_done_s && (bit_cnt_r == 3'd7)) ? ST_PARITY : ST_DATA;
            ST_PARITY: state_next_s = baud_done_s ? ST_STOP : ST_PARITY;
`else
            ST_DATA:   state_next_s = (baud_done_s && (bit_cnt_r == 3'd7)) ? ST_STOP : ST_DATA;
`endif
            ST_STOP:  state_next_s = baud_done_s ? ST_IDLE : ST_STOP;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Line level for the current state
    always_comb begin
        tx_next_s = 1'b1;
        case (state_r)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_r[bit_cnt_r];
`ifdef UART_MMIO_TX_PARITY_EN
            ST_PARITY: tx_next_s = even_parity(shift_r);
`endif
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Registered line driver; the line follows the state by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx_r <= 1'b1;
        end else begin
            uart_tx_r <= tx_next_s;
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and serializer.
// Optional even parity is enabled with UART_MMIO_TX_PARITY_EN.
module uart_mmio_tx
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    output logic [31:0] read_data,
    output logic        uart_tx
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic          sel_s;
    logic [1:0]    offset_s;
    logic          full_s;
    logic          empty_s;
    logic          busy_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic [31:0]   read_data_s;
    logic          unused_s;

    assign sel_s     = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset_s  = addr[3:2];
    assign full_s    = (count_r == FULL_COUNT);
    assign empty_s   = (count_r == '0);
    assign push_s    = sel_s && memwrite && (offset_s == OFF_TXDATA) && !full_s;
    assign ovf_set_s = sel_s && memwrite && (offset_s == OFF_TXDATA) && full_s;
    assign ovf_clr_s = sel_s && memwrite && (offset_s == OFF_STATUS) && write_data[STAT_OVF_BIT];
    assign pop_s     = ready_s && !empty_s;
    assign unused_s  = ^{addr[1:0], write_data[31:8]};

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= write_data[7:0];
        end
    end

    // Pointers and occupancy; a full-FIFO store is dropped even when a pop coincides
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr_s) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Load response decode
    always_comb begin
        read_data_s = 32'h0;
        if (memread && sel_s) begin
            case (offset_s)
                OFF_STATUS: begin
                    read_data_s[STAT_OVF_BIT]   = overflow_r;
                    read_data_s[STAT_BUSY_BIT]  = busy_s;
                    read_data_s[STAT_EMPTY_BIT] = empty_s;
                    read_data_s[STAT_FULL_BIT]  = full_s;
                end
                OFF_LEVEL: read_data_s = 32'(count_r);
                default:   read_data_s = 32'h0;
            endcase
        end else begin
            read_data_s = 32'h0;
        end
    end

    assign read_data = read_data_s;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (!empty_s),
        .byte_data  (fifo_mem_r[rd_ptr_r]),
        .byte_ready (ready_s),
        .busy       (busy_s),
        .uart_tx    (uart_tx)
    );

endmodule
